// File: rtl/spi_master_mcs_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_mcs_if: local data-bus side of spi_master_mcs.  Rev 1.0
// ---------------------------------------------------------------------------
interface spi_master_mcs_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CS_WIDTH   = 2
);
  logic                  im_work_en;
  logic [1:0]            im_mode;
  logic [CS_WIDTH-1:0]   im_cs_sel;
  logic [DATA_WIDTH-1:0] im_data_bus;
  logic [DATA_WIDTH-1:0] om_data_bus;
  logic                  om_work_end;
  logic                  om_busy;
  logic                  om_err;

  modport master (
    output im_work_en, im_mode, im_cs_sel, im_data_bus,
    input  om_data_bus, om_work_end, om_busy, om_err
  );

  modport slave (
    input  im_work_en, im_mode, im_cs_sel, im_data_bus,
    output om_data_bus, om_work_end, om_busy, om_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_mcs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_mcs: multi chip-select SPI master, run-time CPOL/CPHA.  Rev 1.0
// ---------------------------------------------------------------------------
module spi_master_mcs #(
  parameter int DATA_WIDTH            = 8,
  parameter int CNT_WIDTH             = 6,
  parameter int CS_NUM                = 4,
  parameter int CS_WIDTH              = 2,
  parameter int HALF_CLK_PERIOD       = 100,
  parameter int HALF_CLK_PERIOD_WIDTH = 7,
  parameter int CS_SETUP              = 4,
  parameter int CS_HOLD               = 4,
  parameter bit LSB_FIRST             = 1'b0
) (
  input  wire                 clk,
  input  wire                 rst_n,
  spi_master_mcs_if.slave     bus_if,
  input  wire                 im_miso_wire,
  output logic                om_mosi_wire,
  output logic                om_sclk_wire,
  output logic [CS_NUM-1:0]   om_cs_n_wire
);

  localparam int C_TIM_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TW        = $clog2(C_TIM_MAX) + 1;

  localparam logic [TW-1:0]                    C_SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0]                    C_HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [HALF_CLK_PERIOD_WIDTH-1:0] C_HALF_LAST  =
    HALF_CLK_PERIOD_WIDTH'(HALF_CLK_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0]             C_EDGE_LAST  = CNT_WIDTH'(2 * DATA_WIDTH - 1);
  localparam logic [CS_NUM-1:0]                C_CS_ONE     = CS_NUM'(1);
  localparam logic [31:0]                      C_CS_NUM     = 32'(CS_NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [1:0]                       mode_q, mode_d;
  logic [CS_NUM-1:0]                cs_n_q, cs_n_d;
  logic                             sclk_q, sclk_d;
  logic                             mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0]            tx_q, tx_d;
  logic [DATA_WIDTH-1:0]            rx_q, rx_d;
  logic [DATA_WIDTH-1:0]            data_q, data_d;
  logic                             work_end_q, work_end_d;
  logic                             busy_q, busy_d;
  logic                             err_q, err_d;
  logic [HALF_CLK_PERIOD_WIDTH-1:0] half_q, half_d;
  logic [CNT_WIDTH-1:0]             edge_q, edge_d;
  logic [TW-1:0]                    tim_q, tim_d;

  logic w_sel_ok;
  logic w_tick;
  logic w_lead;
  logic w_last;
  logic w_sample;

  function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return LSB_FIRST ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  assign w_sel_ok = ({{(32-CS_WIDTH){1'b0}}, bus_if.im_cs_sel} < C_CS_NUM);
  assign w_tick   = (half_q == C_HALF_LAST);
  assign w_lead   = ~edge_q[0];
  assign w_last   = (edge_q == C_EDGE_LAST);
  // Sample on leading edges for CPHA=0 and on trailing edges for CPHA=1.
  assign w_sample = w_lead ^ mode_q[0];

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_d     = data_q;
    work_end_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    half_d     = half_q;
    edge_d     = edge_q;
    tim_d      = tim_q;

    case (state_q)
      S_IDLE: begin
        if (bus_if.im_work_en) begin
          if (w_sel_ok) begin
            mode_d  = bus_if.im_mode;
            cs_n_d  = ~(C_CS_ONE << bus_if.im_cs_sel);
            sclk_d  = bus_if.im_mode[1];
            busy_d  = 1'b1;
            rx_d    = '0;
            tim_d   = '0;
            state_d = S_SETUP;
            if (!bus_if.im_mode[0]) begin
              mosi_d = tx_bit(bus_if.im_data_bus);
              tx_d   = tx_shift(bus_if.im_data_bus);
            end else begin
              tx_d   = bus_if.im_data_bus;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (tim_q == C_SETUP_LAST) begin
          half_d  = '0;
          edge_d  = '0;
          state_d = S_XFER;
        end else begin
          tim_d = tim_q + 1'b1;
        end
      end

      S_XFER: begin
        if (w_tick) begin
          half_d = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (w_sample) begin
            rx_d = rx_shift(rx_q, im_miso_wire);
          end else if (!w_last) begin
            mosi_d = tx_bit(tx_q);
            tx_d   = tx_shift(tx_q);
          end
          if (w_last) begin
            tim_d   = '0;
            state_d = S_HOLD;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (tim_q == C_HOLD_LAST) begin
          cs_n_d     = '1;
          mosi_d     = 1'b0;
          sclk_d     = mode_q[1];
          data_d     = rx_q;
          work_end_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tim_d = tim_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      cs_n_q     <= '1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_q     <= '0;
      work_end_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      half_q     <= '0;
      edge_q     <= '0;
      tim_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      work_end_q <= work_end_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      half_q     <= half_d;
      edge_q     <= edge_d;
      tim_q      <= tim_d;
    end
  end

  assign bus_if.om_data_bus = data_q;
  assign bus_if.om_work_end = work_end_q;
  assign bus_if.om_busy     = busy_q;
  assign bus_if.om_err      = err_q;
  assign om_mosi_wire       = mosi_q;
  assign om_sclk_wire       = sclk_q;
  assign om_cs_n_wire       = cs_n_q;

endmodule
`default_nettype wire
